// File: rtl/maf_align_if.sv
// Handshake and result bus of the MAF alignment sequencer.
// Valid/ready rule on both sides: a transfer happens on a rising clk edge
// where valid and ready are both high; valid never waits on ready, and
// the payload is held stable while valid is high without ready.
interface maf_align_if #(
  parameter int size_exponent = 8,
  parameter int shift_step    = 8
);
  localparam int ew = size_exponent + 1;
  localparam int aw = $clog2(shift_step + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [ew-1:0]            exp_ab;
  logic [size_exponent-1:0] exp_c;
  logic                     abort;
  logic                     shift_en;
  logic [aw-1:0]            shift_amt;
  logic                     out_valid;
  logic                     out_ready;
  logic                     swap;
  logic [ew-1:0]            exp_max;
  logic [ew-1:0]            shift_total;
  logic                     shift_sat;
  logic                     busy;
  logic [1:0]               state_dbg;

  modport master (
    output in_valid, exp_ab, exp_c, abort, out_ready,
    input  in_ready, shift_en, shift_amt, out_valid, swap, exp_max,
           shift_total, shift_sat, busy, state_dbg
  );

  modport slave (
    input  in_valid, exp_ab, exp_c, abort, out_ready,
    output in_ready, shift_en, shift_amt, out_valid, swap, exp_max,
           shift_total, shift_sat, busy, state_dbg
  );
endinterface

// File: rtl/maf_align_sequencer.sv
// Alignment controller for the MAF datapath: compares product and addend
// exponents, saturates the alignment distance and doles it out to a narrow
// shared shifter at most shift_step bits per cycle, then holds the result
// until the adder takes it.
module maf_align_sequencer #(
  parameter int size_exponent = 8,
  parameter int size_mantissa = 24,
  parameter int shift_step    = 8
) (
  input logic        clk,
  input logic        rst_n,
  maf_align_if.slave bus
);
  localparam int ew = size_exponent + 1;
  localparam int aw = $clog2(shift_step + 1);
  localparam logic [ew-1:0] max_shift = ew'(3 * size_mantissa + 2);
  localparam logic [ew-1:0] step      = ew'(shift_step);

  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  state_t                   state;
  logic [ew-1:0]            ab_q;
  logic [size_exponent-1:0] c_q;
  logic [ew-1:0]            remaining;
  logic                     in_ready_q;
  logic                     shift_en_q;
  logic [aw-1:0]            shift_amt_q;
  logic                     out_valid_q;
  logic                     swap_q;
  logic [ew-1:0]            exp_max_q;
  logic [ew-1:0]            shift_total_q;
  logic                     shift_sat_q;

  logic                     cmp_swap;
  logic [ew-1:0]            cmp_diff;
  logic [ew-1:0]            cmp_total;
  logic [ew-1:0]            cmp_first;
  logic [ew-1:0]            rem_step;

  // Compare the captured exponents; the subtraction always takes the
  // smaller from the larger so the distance never wraps.
  assign cmp_swap  = ({1'b0, c_q} < ab_q);
  assign cmp_diff  = cmp_swap ? (ab_q - {1'b0, c_q}) : ({1'b0, c_q} - ab_q);
  assign cmp_total = (cmp_diff > max_shift) ? max_shift : cmp_diff;
  assign cmp_first = (cmp_total > step) ? step : cmp_total;
  assign rem_step  = (remaining > step) ? step : remaining;

  // Sequencer FSM; every output is a register so the adder and the shifter
  // see glitch-free controls. "remaining" counts bits not yet issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ab_q          <= '0;
      c_q           <= '0;
      remaining     <= '0;
      in_ready_q    <= 1'b1;
      shift_en_q    <= 1'b0;
      shift_amt_q   <= '0;
      out_valid_q   <= 1'b0;
      swap_q        <= 1'b0;
      exp_max_q     <= '0;
      shift_total_q <= '0;
      shift_sat_q   <= 1'b0;
    end else if (state != IDLE && bus.abort) begin
      // Flush wins over everything once an operation is in flight.
      state       <= IDLE;
      remaining   <= '0;
      in_ready_q  <= 1'b1;
      shift_en_q  <= 1'b0;
      shift_amt_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q && !bus.abort) begin
            ab_q       <= bus.exp_ab;
            c_q        <= bus.exp_c;
            in_ready_q <= 1'b0;
            state      <= CMP;
          end
        end
        CMP: begin
          swap_q        <= cmp_swap;
          exp_max_q     <= cmp_swap ? ab_q : {1'b0, c_q};
          shift_total_q <= cmp_total;
          shift_sat_q   <= (cmp_diff > max_shift);
          if (cmp_total == '0) begin
            remaining   <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            shift_en_q  <= 1'b1;
            shift_amt_q <= aw'(cmp_first);
            remaining   <= cmp_total - cmp_first;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (remaining == '0) begin
            shift_en_q  <= 1'b0;
            shift_amt_q <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            shift_amt_q <= aw'(rem_step);
            remaining   <= remaining - rem_step;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.shift_en    = shift_en_q;
  assign bus.shift_amt   = shift_amt_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.swap        = swap_q;
  assign bus.exp_max     = exp_max_q;
  assign bus.shift_total = shift_total_q;
  assign bus.shift_sat   = shift_sat_q;
  assign bus.busy        = (state != IDLE);
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_maf_align_sequencer.sv
// Directed bench for maf_align_sequencer: a driver issues exponent pairs
// and pushes hand-computed results, shift amounts and latencies into
// queues; a negedge monitor pops and compares whenever the DUT shifts or
// presents a result.
module tb_maf_align_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maf_align_if #(.size_exponent(8), .shift_step(8)) bus ();

  maf_align_sequencer #(.size_exponent(8), .size_mantissa(24), .shift_step(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  // result word: {swap, exp_max[8:0], shift_total[8:0], shift_sat}
  logic [19:0] exp_q[$];
  logic [3:0]  amt_q[$];
  int          lat_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_valid = 1'b0;
  logic        hs_pend = 1'b0;
  logic [19:0] held;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hs_pend) begin
        chk("in_ready_after_handshake", int'(bus.in_ready), 1);
        hs_pend = 1'b0;
      end
      if (bus.busy) chk("in_ready_low_while_busy", int'(bus.in_ready), 0);
      if (bus.shift_en) begin
        if (amt_q.size() == 0) chk("unexpected_shift_en", 1, 0);
        else chk("shift_amt", int'(bus.shift_amt), int'(amt_q.pop_front()));
      end else if (bus.shift_amt != 4'd0) begin
        chk("shift_amt_idle_zero", int'(bus.shift_amt), 0);
      end
      if (bus.out_valid && !prev_valid) begin
        held = {bus.swap, bus.exp_max, bus.shift_total, bus.shift_sat};
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          chk("swap", int'(bus.swap), int'(e[19]));
          chk("exp_max", int'(bus.exp_max), int'(e[18:10]));
          chk("shift_total", int'(bus.shift_total), int'(e[9:1]));
          chk("shift_sat", int'(bus.shift_sat), int'(e[0]));
          chk("out_valid_cycle", cyc, lat_q.pop_front());
        end
      end else if (bus.out_valid) begin
        chk("result_stable", int'({bus.swap, bus.exp_max, bus.shift_total, bus.shift_sat}), int'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("in_ready_low_at_handshake", int'(bus.in_ready), 0);
        hs_pend = 1'b1;
      end
      prev_valid = bus.out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [8:0] ab, input logic [7:0] c, output int acc);
    int k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.exp_ab   = ab;
    bus.exp_c    = c;
    @(posedge clk);
    #1;
    acc = cyc;  // CMP occupies this cycle
    bus.in_valid = 1'b0;
  endtask

  // Shifter issue pattern: full steps of 8, then the remainder.
  task automatic push_amts(input int total);
    int rem = total;
    while (rem > 0) begin
      amt_q.push_back((rem > 8) ? 4'd8 : 4'(rem));
      rem -= (rem > 8) ? 8 : rem;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || amt_q.size() != 0 || hs_pend) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", int'(exp_q.size() + amt_q.size()), 0);
  endtask

  task automatic run_vec(input logic [8:0] ab, input logic [7:0] c, input logic sw,
                         input logic [8:0] mx, input logic [8:0] tot, input logic sat,
                         input int n, input int stall);
    int acc;
    issue(ab, c, acc);
    exp_q.push_back({sw, mx, tot, sat});
    // CMP at acc, SHIFT at acc+1..acc+n, first DONE cycle acc+n+1
    lat_q.push_back(acc + n + 1);
    push_amts(int'(tot));
    if (stall > 0) begin
      int k = 0;
      bus.out_ready = 1'b0;
      while (!bus.out_valid && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
      repeat (stall) @(negedge clk);
      bus.out_ready = 1'b1;
    end
    wait_drain();
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int acc;
    int seen;
    bus.in_valid  = 1'b0;
    bus.exp_ab    = '0;
    bus.exp_c     = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_shift_en", int'(bus.shift_en), 0);
    chk("reset_shift_total", int'(bus.shift_total), 0);
    rst_n = 1'b1;

    //      ab   c   swap max  tot sat n  stall
    run_vec(130, 127, 1, 130,  3, 0, 1, 0);   // T1
    run_vec(100, 120, 0, 120, 20, 0, 3, 0);   // T2
    run_vec(127, 127, 0, 127,  0, 0, 0, 0);   // T3 equal
    run_vec(400,  10, 1, 400, 74, 1, 10, 0);  // T4 saturated
    run_vec(130, 127, 1, 130,  3, 0, 1, 5);   // T5 held in DONE
    run_vec( 84,  10, 1,  84, 74, 0, 10, 0);  // distance exactly max_shift
    run_vec( 85,  10, 1,  85, 74, 1, 10, 0);  // one past max_shift
    run_vec(  8,   0, 1,   8,  8, 0, 1, 0);   // exactly one step
    run_vec(  9,   0, 1,   9,  9, 0, 2, 0);   // one step plus one
    run_vec(  0, 255, 0, 255, 74, 1, 10, 2);  // addend larger, saturated
    run_vec(511, 255, 1, 511, 74, 1, 10, 0);  // top of product range

    // abort in IDLE is ignored and also blocks acceptance
    @(negedge clk);
    bus.abort = 1'b1;
    bus.in_valid = 1'b1;
    bus.exp_ab = 9'd50;
    bus.exp_c = 8'd1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_idle_busy", int'(bus.busy), 0);
    chk("abort_idle_in_ready", int'(bus.in_ready), 1);

    // T6a: abort on the second SHIFT cycle of T2
    issue(100, 120, acc);
    amt_q.push_back(4'd8);
    amt_q.push_back(4'd8);
    @(posedge clk);
    #1;  // first SHIFT cycle
    @(posedge clk);
    #1;  // second SHIFT cycle
    chk("abort_shift_active", int'(bus.shift_en), 1);
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_state_idle", int'(bus.busy), 0);
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_shift_en", int'(bus.shift_en), 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid || bus.shift_en) seen++;
    end
    chk("abort_no_more_output", seen, 0);
    chk("abort_amts_consumed", int'(amt_q.size()), 0);

    // T6b: reset pulse mid-SHIFT
    issue(400, 10, acc);
    amt_q.push_back(4'd8);
    @(posedge clk);
    #1;  // first SHIFT cycle, sampled by monitor
    @(posedge clk);
    #2;
    chk("pre_reset_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_shift_en", int'(bus.shift_en), 0);
    chk("rst_shift_amt", int'(bus.shift_amt), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_result", int'({bus.swap, bus.exp_max, bus.shift_total, bus.shift_sat}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_amts_consumed", int'(amt_q.size()), 0);
    prev_valid = 1'b0;

    // recovery after reset
    run_vec(100, 120, 0, 120, 20, 0, 3, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
